// File: rtl/voice_allocator_if.sv
// Note-event handshake between the keycode event logic and the voice allocator.
interface voice_allocator_if #(
  parameter int KEY_W = 8
);
  logic             evt_valid;
  logic             evt_ready;
  logic             evt_on;
  logic [KEY_W-1:0] evt_key;

  // Event source: presents note events and watches ready.
  modport master (output evt_valid, output evt_on, output evt_key, input evt_ready);
  // Allocator side: consumes note events and drives ready.
  modport slave  (input evt_valid, input evt_on, input evt_key, output evt_ready);
endinterface

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: schedules note-on/off events onto a fixed voice
// pool with a sequential one-voice-per-cycle scan of the voice table.
//
// state  | meaning
// IDLE   | ready for an event (evt_ready high unless all_off)
// SCAN   | walking voices 0..NUM_VOICES-1, collecting match/free/oldest
// COMMIT | applying the allocation, retrigger, release or steal
module voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int KEY_W      = 8,
  parameter int AGE_W      = 4,
  parameter int IDX_W      = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  voice_allocator_if.slave            evt,
  input  logic                        all_off,
  output logic [NUM_VOICES-1:0]       voice_active,
  output logic [NUM_VOICES*KEY_W-1:0] voice_key,
  output logic [NUM_VOICES-1:0]       voice_trig,
  output logic                        steal,
  output logic                        busy
);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  state_t           state;
  logic             lat_on;
  logic [KEY_W-1:0] lat_key;
  logic [IDX_W-1:0] scan_idx;
  logic             match_found, free_found, old_found;
  logic [IDX_W-1:0] match_idx, free_idx, old_idx;
  logic [AGE_W-1:0] old_age;
  logic [AGE_W-1:0] age [NUM_VOICES];

  logic             cur_active;
  logic [KEY_W-1:0] cur_key;
  logic [AGE_W-1:0] cur_age;
  logic [IDX_W-1:0] tgt;
  logic             do_on;

  // Current scan entry and commit target selection (match > free > oldest).
  always_comb begin
    cur_active = voice_active[scan_idx];
    cur_key    = voice_key[int'(scan_idx)*KEY_W +: KEY_W];
    cur_age    = age[scan_idx];
    tgt        = match_found ? match_idx : (free_found ? free_idx : old_idx);
    do_on      = lat_on && (lat_key != '0);
  end

  // Main FSM with registered voice table, pulses and handshake ready.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      evt.evt_ready <= 1'b1;
      busy          <= 1'b0;
      voice_active  <= '0;
      voice_key     <= '0;
      voice_trig    <= '0;
      steal         <= 1'b0;
      lat_on        <= 1'b0;
      lat_key       <= '0;
      scan_idx      <= '0;
      match_found   <= 1'b0;
      free_found    <= 1'b0;
      old_found     <= 1'b0;
      match_idx     <= '0;
      free_idx      <= '0;
      old_idx       <= '0;
      old_age       <= '0;
      for (int i = 0; i < NUM_VOICES; i++) age[i] <= '0;
    end else begin
      voice_trig <= '0;
      steal      <= 1'b0;
      if (all_off) begin
        // Panic wins over everything, including a same-cycle handshake.
        state         <= IDLE;
        evt.evt_ready <= 1'b0;
        busy          <= 1'b0;
        voice_active  <= '0;
        voice_key     <= '0;
        for (int i = 0; i < NUM_VOICES; i++) age[i] <= '0;
      end else begin
        case (state)
          IDLE: begin
            evt.evt_ready <= 1'b1;
            if (evt.evt_valid && evt.evt_ready) begin
              lat_on        <= evt.evt_on;
              lat_key       <= evt.evt_key;
              scan_idx      <= '0;
              match_found   <= 1'b0;
              free_found    <= 1'b0;
              old_found     <= 1'b0;
              match_idx     <= '0;
              free_idx      <= '0;
              old_idx       <= '0;
              old_age       <= '0;
              state         <= SCAN;
              busy          <= 1'b1;
              evt.evt_ready <= 1'b0;
            end
          end
          SCAN: begin
            if (cur_active && (cur_key == lat_key) && !match_found) begin
              match_found <= 1'b1;
              match_idx   <= scan_idx;
            end
            if (!cur_active && !free_found) begin
              free_found <= 1'b1;
              free_idx   <= scan_idx;
            end
            // Strict '>' keeps the lowest index on equal ages.
            if (cur_active && (!old_found || (cur_age > old_age))) begin
              old_found <= 1'b1;
              old_idx   <= scan_idx;
              old_age   <= cur_age;
            end
            if (scan_idx == LAST_IDX) state <= COMMIT;
            else                      scan_idx <= scan_idx + 1'b1;
          end
          COMMIT: begin
            state         <= IDLE;
            busy          <= 1'b0;
            evt.evt_ready <= 1'b1;
            if (do_on) begin
              for (int i = 0; i < NUM_VOICES; i++) begin
                if (IDX_W'(i) == tgt) begin
                  voice_active[i]              <= 1'b1;
                  voice_key[i*KEY_W +: KEY_W]  <= lat_key;
                  voice_trig[i]                <= 1'b1;
                  age[i]                       <= '0;
                end else if (voice_active[i] && (age[i] != '1)) begin
                  age[i] <= age[i] + 1'b1;
                end
              end
              steal <= !match_found && !free_found;
            end else if (!lat_on && match_found) begin
              for (int i = 0; i < NUM_VOICES; i++) begin
                if (IDX_W'(i) == match_idx) begin
                  voice_active[i]             <= 1'b0;
                  voice_key[i*KEY_W +: KEY_W] <= '0;
                  age[i]                      <= '0;
                end
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: two instances (AGE_W=4 and AGE_W=2)
// receive identical events and are checked against the same expectations.
module tb_voice_allocator;

  typedef struct {
    logic        on;
    logic [7:0]  key;
    logic        panic;
    logic [3:0]  act;
    logic [31:0] keys;
    logic [3:0]  trig;
    logic        st;
  } rec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic valid = 1'b0, on = 1'b0, all_off = 1'b0;
  logic [7:0] key = 8'h00;

  logic [3:0]  act_a, trig_a, act_b, trig_b;
  logic [31:0] key_a, key_b;
  logic        steal_a, busy_a, steal_b, busy_b;

  int checks = 0;
  int errors = 0;
  logic [3:0]  prev_act = 4'b0;
  rec_t tbl [23];

  always #5 clk = ~clk;

  voice_allocator_if #(.KEY_W(8)) ifa ();
  voice_allocator_if #(.KEY_W(8)) ifb ();
  assign ifa.evt_valid = valid;
  assign ifa.evt_on    = on;
  assign ifa.evt_key   = key;
  assign ifb.evt_valid = valid;
  assign ifb.evt_on    = on;
  assign ifb.evt_key   = key;

  voice_allocator #(.NUM_VOICES(4), .KEY_W(8), .AGE_W(4), .IDX_W(2)) dut_a (
    .clk(clk), .reset_n(reset_n), .evt(ifa), .all_off(all_off),
    .voice_active(act_a), .voice_key(key_a), .voice_trig(trig_a),
    .steal(steal_a), .busy(busy_a));

  voice_allocator #(.NUM_VOICES(4), .KEY_W(8), .AGE_W(2), .IDX_W(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .evt(ifb), .all_off(all_off),
    .voice_active(act_b), .voice_key(key_b), .voice_trig(trig_b),
    .steal(steal_b), .busy(busy_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [3:0] ea, input logic [31:0] ek,
                          input logic [3:0] et, input logic es);
    chk({tag, " active_a"}, 32'(act_a), 32'(ea));
    chk({tag, " key_a"},    key_a,      ek);
    chk({tag, " trig_a"},   32'(trig_a), 32'(et));
    chk({tag, " steal_a"},  32'(steal_a), 32'(es));
    chk({tag, " active_b"}, 32'(act_b), 32'(ea));
    chk({tag, " key_b"},    key_b,      ek);
    chk({tag, " trig_b"},   32'(trig_b), 32'(et));
    chk({tag, " steal_b"},  32'(steal_b), 32'(es));
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    @(negedge clk);
    while (!(ifa.evt_ready && ifb.evt_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      errors++;
      $display("FAIL %s ready_timeout actual=0 expected=1", tag);
    end
  endtask

  task automatic pulse_panic(input string tag);
    @(negedge clk);
    all_off = 1'b1;
    @(posedge clk); #1;
    chk_outs(tag, 4'b0, 32'h0, 4'b0, 1'b0);
    chk({tag, " busy"}, 32'({busy_a, busy_b}), 32'h0);
    @(negedge clk);
    all_off = 1'b0;
    @(posedge clk); #1;
    chk({tag, " ready"}, 32'({ifa.evt_ready, ifb.evt_ready}), 32'h3);
    prev_act = 4'b0;
  endtask

  task automatic apply(input string tag, input rec_t r);
    int lowcnt = 0;
    if (r.panic) begin
      pulse_panic(tag);
    end else begin
      wait_ready(tag);
      valid = 1'b1; on = r.on; key = r.key;
      @(posedge clk); #1;
      valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
        if (!ifa.evt_ready && !ifb.evt_ready && trig_a == 4'b0 && trig_b == 4'b0 &&
            act_a == prev_act && act_b == prev_act && busy_a && busy_b)
          lowcnt++;
        @(posedge clk); #1;
      end
      chk({tag, " busy_window"}, 32'(lowcnt), 32'd5);
      chk_outs(tag, r.act, r.keys, r.trig, r.st);
      chk({tag, " ready_back"}, 32'({ifa.evt_ready, ifb.evt_ready}), 32'h3);
      @(posedge clk); #1;
      chk({tag, " pulse_clear"}, 32'({trig_a, trig_b, steal_a, steal_b}), 32'h0);
      prev_act = r.act;
    end
  endtask

  initial begin
    int hs_a [$];
    int hs_b [$];
    int bad;

    tbl[0]  = '{1'b1, 8'h3C, 1'b0, 4'b0001, 32'h0000003C, 4'b0001, 1'b0};
    tbl[1]  = '{1'b1, 8'h3E, 1'b0, 4'b0011, 32'h00003E3C, 4'b0010, 1'b0};
    tbl[2]  = '{1'b1, 8'h3C, 1'b0, 4'b0011, 32'h00003E3C, 4'b0001, 1'b0};
    tbl[3]  = '{1'b0, 8'h3E, 1'b0, 4'b0001, 32'h0000003C, 4'b0000, 1'b0};
    tbl[4]  = '{1'b0, 8'h50, 1'b0, 4'b0001, 32'h0000003C, 4'b0000, 1'b0};
    tbl[5]  = '{1'b1, 8'h00, 1'b0, 4'b0001, 32'h0000003C, 4'b0000, 1'b0};
    tbl[6]  = '{1'b1, 8'h3E, 1'b0, 4'b0011, 32'h00003E3C, 4'b0010, 1'b0};
    tbl[7]  = '{1'b1, 8'h40, 1'b0, 4'b0111, 32'h00403E3C, 4'b0100, 1'b0};
    tbl[8]  = '{1'b1, 8'h41, 1'b0, 4'b1111, 32'h41403E3C, 4'b1000, 1'b0};
    tbl[9]  = '{1'b1, 8'h43, 1'b0, 4'b1111, 32'h41403E43, 4'b0001, 1'b1};
    tbl[10] = '{1'b1, 8'h44, 1'b0, 4'b1111, 32'h41404443, 4'b0010, 1'b1};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 4'b0000, 32'h00000000, 4'b0000, 1'b0};
    tbl[12] = '{1'b1, 8'h10, 1'b0, 4'b0001, 32'h00000010, 4'b0001, 1'b0};
    tbl[13] = '{1'b1, 8'h20, 1'b0, 4'b0011, 32'h00002010, 4'b0010, 1'b0};
    for (int i = 14; i < 19; i++)
      tbl[i] = '{1'b1, 8'h20, 1'b0, 4'b0011, 32'h00002010, 4'b0010, 1'b0};
    tbl[19] = '{1'b1, 8'h30, 1'b0, 4'b0111, 32'h00302010, 4'b0100, 1'b0};
    tbl[20] = '{1'b1, 8'h31, 1'b0, 4'b1111, 32'h31302010, 4'b1000, 1'b0};
    tbl[21] = '{1'b1, 8'h32, 1'b0, 4'b1111, 32'h31302032, 4'b0001, 1'b1};
    tbl[22] = '{1'b0, 8'h00, 1'b1, 4'b0000, 32'h00000000, 4'b0000, 1'b0};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk_outs("reset", 4'b0, 32'h0, 4'b0, 1'b0);
    chk("reset busy",  32'({busy_a, busy_b}), 32'h0);
    chk("reset ready", 32'({ifa.evt_ready, ifb.evt_ready}), 32'h3);
    @(negedge clk);
    reset_n = 1'b1;

    // Table: allocation, retrigger, release, no-ops, stealing, age saturation
    for (int i = 0; i < 23; i++)
      apply($sformatf("vec%0d", i), tbl[i]);

    // Back-to-back events with valid held: one accept per 6 cycles
    @(negedge clk);
    valid = 1'b1; on = 1'b0; key = 8'h77;
    for (int c = 0; c < 36; c++) begin
      if (ifa.evt_ready) hs_a.push_back(c);
      if (ifb.evt_ready) hs_b.push_back(c);
      @(negedge clk);
    end
    valid = 1'b0;
    chk("b2b count_a", 32'(hs_a.size()), 32'd6);
    chk("b2b count_b", 32'(hs_b.size()), 32'd6);
    bad = 0;
    for (int i = 1; i < hs_a.size(); i++)
      if (hs_a[i] - hs_a[i-1] != 6) bad++;
    chk("b2b spacing", 32'(bad), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    chk_outs("b2b end", 4'b0, 32'h0, 4'b0, 1'b0);

    // all_off during SCAN of a note-on with three voices active
    apply("pre60", rec_t'{1'b1, 8'h60, 1'b0, 4'b0001, 32'h00000060, 4'b0001, 1'b0});
    apply("pre61", rec_t'{1'b1, 8'h61, 1'b0, 4'b0011, 32'h00006160, 4'b0010, 1'b0});
    apply("pre62", rec_t'{1'b1, 8'h62, 1'b0, 4'b0111, 32'h00626160, 4'b0100, 1'b0});
    wait_ready("drop63");
    valid = 1'b1; on = 1'b1; key = 8'h63;
    @(posedge clk); #1;
    valid = 1'b0;
    @(negedge clk);
    all_off = 1'b1;
    @(posedge clk); #1;
    chk_outs("alloff", 4'b0, 32'h0, 4'b0, 1'b0);
    chk("alloff busy", 32'({busy_a, busy_b}), 32'h0);
    @(negedge clk);
    all_off = 1'b0;
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (trig_a != 4'b0 || trig_b != 4'b0 || act_a != 4'b0 || act_b != 4'b0 ||
          key_a != 32'h0 || key_b != 32'h0 || busy_a || busy_b) bad++;
    end
    chk("alloff quiet", 32'(bad), 32'd0);
    chk("alloff ready", 32'({ifa.evt_ready, ifb.evt_ready}), 32'h3);
    prev_act = 4'b0;
    apply("post64", rec_t'{1'b1, 8'h64, 1'b0, 4'b0001, 32'h00000064, 4'b0001, 1'b0});

    // Asynchronous reset in the middle of a scan
    wait_ready("rst65");
    valid = 1'b1; on = 1'b1; key = 8'h65;
    @(posedge clk); #1;
    valid = 1'b0;
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    chk_outs("async_rst", 4'b0, 32'h0, 4'b0, 1'b0);
    chk("async_rst busy",  32'({busy_a, busy_b}), 32'h0);
    chk("async_rst ready", 32'({ifa.evt_ready, ifb.evt_ready}), 32'h3);
    @(negedge clk);
    reset_n = 1'b1;
    prev_act = 4'b0;
    apply("post66", rec_t'{1'b1, 8'h66, 1'b0, 4'b0001, 32'h00000066, 4'b0001, 1'b0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
